// File: rtl/series_pkg.sv
// Shared constants and types for the series-evaluation pipeline.
// Q1.31 limits and the {ovf, sum} result entry carried through the output FIFO.
package series_pkg;

    localparam int DEF_DATA_W = 32;

    localparam logic [DEF_DATA_W-1:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [DEF_DATA_W-1:0] Q_MIN = 32'h8000_0000;

    typedef struct packed {
        logic                  ovf;
        logic [DEF_DATA_W-1:0] sum;
    } result_t;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO with synchronous flush; head reads as zero when empty.
// Pointers carry an extra wrap bit so full and empty are unambiguous.
module result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Flush wins over both ports; a full FIFO never accepts, even alongside a pop.
    assign w_push = i_wr_en && !o_full && !i_flush;
    assign w_pop  = i_rd_en && !o_empty && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/pipe_result_collector.sv
// Collects final Q1.31 sums from the last pipe slice, optionally saturating overflowed
// results, buffering them in a FWFT FIFO and keeping saturating result/overflow counters.
module pipe_result_collector
    import series_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  result_count,
    output logic [CNT_W-1:0]  ovf_count
);

    localparam logic [DATA_W-1:0] W_SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] W_SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic [DATA_W-1:0] w_store_sum;
    logic [DATA_W:0]   w_wr_data;
    logic [DATA_W:0]   w_rd_data;
    logic [1:0]        w_cnt_inc;
    logic [CNT_W-1:0]  r_cnt [2];

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready && !flush;

    // An overflowed sum has wrapped, so its sign bit is the opposite of the true sign.
    generate
        if (SATURATE) begin : g_sat
            assign w_store_sum = !in_ovf ? in_sum :
                                 (in_sum[DATA_W-1] ? W_SAT_MAX : W_SAT_MIN);
        end else begin : g_raw
            assign w_store_sum = in_sum;
        end
    endgenerate

    assign w_wr_data = {in_ovf, w_store_sum};

    result_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_wr_en   (w_push),
        .i_wr_data (w_wr_data),
        .i_rd_en   (out_ready),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign out_ovf    = w_rd_data[DATA_W];
    assign out_result = w_rd_data[DATA_W-1:0];

    // Index 0 counts every accepted result, index 1 only the overflowed ones.
    assign w_cnt_inc[0] = w_push;
    assign w_cnt_inc[1] = w_push && in_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt[gi] <= '0;
                end else if (flush) begin
                    r_cnt[gi] <= '0;
                end else if (w_cnt_inc[gi] && !(&r_cnt[gi])) begin
                    r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign result_count = r_cnt[0];
    assign ovf_count    = r_cnt[1];

endmodule

// File: tb/tb_pipe_result_collector.sv
// Bench for pipe_result_collector: directed scenarios plus random traffic, checked every
// cycle against a queue model; a second instance (CNT_W=4, SATURATE=0) shares the stimulus.
module tb_pipe_result_collector;
    import series_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_sum = '0;
    logic        in_ovf = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [31:0] a_out_result;
    logic [15:0] a_result_count, a_ovf_count;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [31:0] b_out_result;
    logic [3:0]  b_result_count, b_ovf_count;

    int n_vec = 0;
    int n_err = 0;

    result_t q_a[$];
    result_t q_b[$];
    int cnt_ra = 0, cnt_oa = 0, cnt_rb = 0, cnt_ob = 0;
    bit do_pop, do_push;
    result_t e_a, e_b;

    always #5 clk = ~clk;

    pipe_result_collector #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(16), .SATURATE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_sum(in_sum), .in_ovf(in_ovf), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_result(a_out_result), .out_ovf(a_out_ovf),
        .result_count(a_result_count), .ovf_count(a_ovf_count)
    );

    pipe_result_collector #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(4), .SATURATE(1'b0)) u_dut_c4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sum(in_sum), .in_ovf(in_ovf), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_result(b_out_result), .out_ovf(b_out_ovf),
        .result_count(b_result_count), .ovf_count(b_ovf_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %0s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        q_a.delete();
        q_b.delete();
        cnt_ra = 0; cnt_oa = 0; cnt_rb = 0; cnt_ob = 0;
    endtask

    // Reference model: a queue of stored entries and plain integer counters.
    always @(posedge clk) begin
        if (!rst) begin
            if (flush) begin
                model_clear();
            end else begin
                do_pop  = (q_a.size() > 0) && out_ready;
                do_push = in_valid && (q_a.size() < DEPTH);
                if (do_pop) begin
                    void'(q_a.pop_front());
                    void'(q_b.pop_front());
                end
                if (do_push) begin
                    e_a.ovf = in_ovf;
                    e_a.sum = in_ovf ? (in_sum[31] ? Q_MAX : Q_MIN) : in_sum;
                    e_b.ovf = in_ovf;
                    e_b.sum = in_sum;
                    q_a.push_back(e_a);
                    q_b.push_back(e_b);
                    if (cnt_ra < 65535) cnt_ra++;
                    if (cnt_rb < 15) cnt_rb++;
                    if (in_ovf && cnt_oa < 65535) cnt_oa++;
                    if (in_ovf && cnt_ob < 15) cnt_ob++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("a_in_ready",  {31'd0, a_in_ready},  {31'd0, q_a.size() < DEPTH});
            chk("a_out_valid", {31'd0, a_out_valid}, {31'd0, q_a.size() > 0});
            chk("a_out_result", a_out_result, (q_a.size() > 0) ? q_a[0].sum : 32'd0);
            chk("a_out_ovf",   {31'd0, a_out_ovf},   {31'd0, (q_a.size() > 0) ? q_a[0].ovf : 1'b0});
            chk("a_result_count", {16'd0, a_result_count}, 32'(cnt_ra));
            chk("a_ovf_count",    {16'd0, a_ovf_count},    32'(cnt_oa));
            chk("b_in_ready",  {31'd0, b_in_ready},  {31'd0, q_b.size() < DEPTH});
            chk("b_out_valid", {31'd0, b_out_valid}, {31'd0, q_b.size() > 0});
            chk("b_out_result", b_out_result, (q_b.size() > 0) ? q_b[0].sum : 32'd0);
            chk("b_out_ovf",   {31'd0, b_out_ovf},   {31'd0, (q_b.size() > 0) ? q_b[0].ovf : 1'b0});
            chk("b_result_count", {28'd0, b_result_count}, 32'(cnt_rb));
            chk("b_ovf_count",    {28'd0, b_ovf_count},    32'(cnt_ob));
        end
    end

    // Present one beat for exactly one clock edge, returning just after that edge.
    task automatic drive(input logic v, input logic [31:0] s, input logic o,
                         input logic r, input logic f);
        in_valid  = v;
        in_sum    = s;
        in_ovf    = o;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #12;
        model_clear();
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("reset_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("reset_in_ready",  {31'd0, a_in_ready},  32'd1);
        chk("reset_out_result", a_out_result, 32'd0);
        chk("reset_counts", {a_result_count, a_ovf_count}, 32'd0);

        // Single push, visible one cycle later.
        drive(1'b1, 32'h2000_0000, 1'b0, 1'b1, 1'b0);
        chk("single_valid",  {31'd0, a_out_valid}, 32'd1);
        chk("single_result", a_out_result, 32'h2000_0000);
        chk("single_ovf",    {31'd0, a_out_ovf}, 32'd0);
        chk("single_counts", {a_result_count, a_ovf_count}, {16'd1, 16'd0});
        idle(2);

        // Saturation in both directions; the raw instance keeps the wrapped value.
        drive(1'b1, 32'h9000_0000, 1'b1, 1'b0, 1'b0);
        chk("sat_pos_result", a_out_result, 32'h7FFF_FFFF);
        chk("sat_pos_ovf",    {31'd0, a_out_ovf}, 32'd1);
        chk("raw_pos_result", b_out_result, 32'h9000_0000);
        drive(1'b1, 32'h1000_0000, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("sat_neg_result", a_out_result, 32'h8000_0000);
        chk("sat_ovf_count",  {16'd0, a_ovf_count}, 32'd2);
        idle(2);

        // Fill and backpressure.
        for (int i = 1; i <= 4; i++) drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        chk("full_in_ready", {31'd0, a_in_ready}, 32'd0);
        drive(1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
        chk("full_ignored_count", {16'd0, a_result_count}, 32'd7);
        chk("fill_head1", a_out_result, 32'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("pop_in_ready", {31'd0, a_in_ready}, 32'd1);
        for (int i = 2; i <= 4; i++) begin
            chk("drain_order", a_out_result, 32'(i));
            drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        end
        chk("drain_empty", {31'd0, a_out_valid}, 32'd0);

        // Simultaneous push/pop at occupancy 2.
        drive(1'b1, 32'd10, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'd11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(12 + i), 1'b0, 1'b1, 1'b0);
            chk("pushpop_head", a_out_result, 32'(11 + i));
        end
        idle(3);
        chk("pushpop_drained", {31'd0, a_out_valid}, 32'd0);

        // Flush with entries queued and a beat presented in the same cycle.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'(100 + i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_DEAD, 1'b0, 1'b0, 1'b1);
        chk("flush_valid",  {31'd0, a_out_valid}, 32'd0);
        chk("flush_counts", {a_result_count, a_ovf_count}, 32'd0);
        idle(3);
        chk("flush_discarded", {31'd0, a_out_valid}, 32'd0);

        // Asynchronous reset between edges with two entries queued.
        drive(1'b1, 32'd200, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'd201, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        chk("areset_valid",  {31'd0, a_out_valid}, 32'd0);
        chk("areset_counts", {a_result_count, a_ovf_count}, 32'd0);
        chk("areset_b_valid", {31'd0, b_out_valid}, 32'd0);
        #2;
        rst = 1'b0;

        // Counter saturation on the CNT_W=4 instance.
        for (int i = 0; i < 17; i++) drive(1'b1, 32'(i), 1'(i % 2), 1'b1, 1'b0);
        chk("c4_result_sat", {28'd0, b_result_count}, 32'hF);
        chk("c16_result_17", {16'd0, a_result_count}, 32'd17);
        chk("c4_ovf_count",  {28'd0, b_ovf_count},    32'd8);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_result_collector.md
Name: pipe_result_collector

Overview:
- Downstream stage of the series-evaluation pipeline; sits after the last pipe slice.
- Captures the final Q1.31 partial sum and the accumulated overflow indication, one result per valid beat.
- Optionally saturates overflowed results, buffers them in a small FIFO and presents them on a valid/ready output.
- Keeps saturating counters of results and of overflowed results for debug/status.

Parameters:
- DATA_W, 32, width of the Q1.31 sum.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the status counters.
- SATURATE, 1, 1 = clamp overflowed results to Q1.31 max/min; 0 = pass the wrapped value unchanged.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- flush  input  1  synchronous clear of the FIFO and counters.
- in_valid  input  1  final slice presents a result this cycle.
- in_ready  output  1  collector can accept the result; equals not-full.
- in_sum  input  DATA_W  signed Q1.31 final sum from the last slice.
- in_ovf  input  1  OR of all slice overflow flags for this result.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head this cycle.
- out_result  output  DATA_W  signed Q1.31 result at the FIFO head.
- out_ovf  output  1  overflow tag of the head entry.
- result_count  output  CNT_W  number of results accepted, saturating.
- ovf_count  output  CNT_W  number of accepted results with in_ovf=1, saturating.

Behaviour:
- Reset (asynchronous, rst=1): FIFO empty, pointers 0, out_valid=0, in_ready=1, out_result=0, out_ovf=0, both counters 0.
- Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
- in_ready = !full. It does not depend on out_ready, so there is no push into a full FIFO even if a pop happens in the same cycle.
- Head output is first-word-fall-through:
  - out_result and out_ovf show the entry at the read pointer.
  - When the FIFO is empty, out_result and out_ovf are forced to 0.
- Latency: a result pushed at edge N is visible with out_valid=1 after edge N (1 cycle).
- Saturation, applied before the write when SATURATE=1 and in_ovf=1:
  - in_sum[31]=1 (positive wrap) stores 32'h7FFFFFFF.
  - in_sum[31]=0 (negative wrap) stores 32'h80000000.
  - The stored ovf tag is 1.
- When SATURATE=0, the raw in_sum is stored with the ovf tag.
- Simultaneous push and pop, non-empty and non-full: occupancy unchanged, both pointers advance.
- Simultaneous push and pop on an empty FIFO: only the push occurs; pop is impossible because out_valid=0.
- Pointers use DEPTH-index wrap with an extra wrap bit, so full and empty are distinguished without ambiguity.
- Counters:
  - result_count increments on each push; ovf_count increments on each push with in_ovf=1.
  - Both hold at all-ones and never wrap.
- flush=1 has priority over push and pop in the same cycle: FIFO empties and counters go to 0 at the next edge; the input beat presented that cycle is discarded.
- rst asserted mid-stream: all state clears immediately; entries in flight are lost; no out_valid glitch after release.

Decomposition:
- Shared package series_pkg:
  - Q_MAX = 32'h7FFFFFFF, Q_MIN = 32'h80000000.
  - DATA_W default.
  - A packed result entry type {ovf, sum}.
- One sub-module: result_fifo.
  - Synchronous FWFT FIFO, width DATA_W+1, parameterised by DEPTH.
  - Has flush and full/empty outputs.
- Saturation logic and counters live in the top module.

Test Plan:
- Reset then single push: in_sum=32'h20000000, in_ovf=0, out_ready=1 -> out_valid=1 one cycle later with out_result=32'h20000000, out_ovf=0; result_count=1, ovf_count=0.
- Saturation:
  - SATURATE=1, push in_sum=32'h9000_0000 with in_ovf=1 -> out_result=32'h7FFFFFFF, out_ovf=1.
  - Then push 32'h1000_0000 with in_ovf=1 -> 32'h80000000.
  - ovf_count=2.
- Fill and backpressure:
  - out_ready=0, push 4 results 1,2,3,4 -> in_ready=0 after the 4th; a 5th in_valid is ignored.
  - Then out_ready=1 -> outputs 1,2,3,4 in order, and in_ready returns to 1 after the first pop.
- Simultaneous push/pop at occupancy 2 for 10 cycles -> occupancy stays 2, order preserved, no loss or duplication.
- Flush with 3 entries plus in_valid=1 in the same cycle -> next cycle out_valid=0, both counters 0, the flushed-cycle input is absent from later output.
- Async reset asserted between clock edges with 2 entries queued -> out_valid drops immediately, counters 0. Counter saturation check: with CNT_W=4, 17 pushes -> result_count=4'hF.
